// File: rtl/pcie_egress_scheduler_pkg.sv
// Shared widths, FSM encoding and packed-slice helper for the PCIe egress scheduler.
// PES_SLICE(vec, idx, w) selects lane idx of a packed per-requester vector.
`ifndef PCIE_EGRESS_SCHEDULER_PKG_SV
`define PCIE_EGRESS_SCHEDULER_PKG_SV

`define PES_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package pcie_egress_scheduler_pkg;

    localparam int CMD_W    = 8;
    localparam int FLAGS_W  = 14;
    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 8;
    localparam int SIZE_W   = 24;
    localparam int DATA_W   = 32;
    localparam int RID_W    = 16;
    localparam int TO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/pcie_egress_scheduler_if.sv
// Requester-side and egress-engine-side bundle of the egress scheduler.
// master: scheduler view; slave: requesters plus engine view.
interface pcie_egress_scheduler_if
    import pcie_egress_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3
) ();

    logic [NUM_REQ-1:0]         i_req;
    logic [NUM_REQ-1:0]         o_gnt;
    logic [NUM_REQ-1:0]         o_done;
    logic                       o_timeout;
    logic [CMD_W*NUM_REQ-1:0]   i_req_command;
    logic [FLAGS_W*NUM_REQ-1:0] i_req_flags;
    logic [ADDR_W*NUM_REQ-1:0]  i_req_address;
    logic [TAG_W*NUM_REQ-1:0]   i_req_tag;
    logic [RID_W-1:0]           i_requester_id;
    logic [NUM_REQ-1:0]         i_req_fifo_rdy;
    logic [NUM_REQ-1:0]         o_req_fifo_act;
    logic [SIZE_W*NUM_REQ-1:0]  i_req_fifo_size;
    logic [DATA_W*NUM_REQ-1:0]  i_req_fifo_data;
    logic [NUM_REQ-1:0]         o_req_fifo_stb;
    logic                       o_eg_enable;
    logic                       i_eg_finished;
    logic [CMD_W-1:0]           o_eg_command;
    logic [FLAGS_W-1:0]         o_eg_flags;
    logic [ADDR_W-1:0]          o_eg_address;
    logic [RID_W-1:0]           o_eg_requester_id;
    logic [TAG_W-1:0]           o_eg_tag;
    logic                       o_eg_fifo_rdy;
    logic                       i_eg_fifo_act;
    logic [SIZE_W-1:0]          o_eg_fifo_size;
    logic [DATA_W-1:0]          o_eg_fifo_data;
    logic                       i_eg_fifo_stb;

    modport master (
        input  i_req, i_req_command, i_req_flags, i_req_address, i_req_tag,
               i_requester_id, i_req_fifo_rdy, i_req_fifo_size, i_req_fifo_data,
               i_eg_finished, i_eg_fifo_act, i_eg_fifo_stb,
        output o_gnt, o_done, o_timeout, o_req_fifo_act, o_req_fifo_stb,
               o_eg_enable, o_eg_command, o_eg_flags, o_eg_address,
               o_eg_requester_id, o_eg_tag, o_eg_fifo_rdy, o_eg_fifo_size, o_eg_fifo_data
    );

    modport slave (
        output i_req, i_req_command, i_req_flags, i_req_address, i_req_tag,
               i_requester_id, i_req_fifo_rdy, i_req_fifo_size, i_req_fifo_data,
               i_eg_finished, i_eg_fifo_act, i_eg_fifo_stb,
        input  o_gnt, o_done, o_timeout, o_req_fifo_act, o_req_fifo_stb,
               o_eg_enable, o_eg_command, o_eg_flags, o_eg_address,
               o_eg_requester_id, o_eg_tag, o_eg_fifo_rdy, o_eg_fifo_size, o_eg_fifo_data
    );

endinterface

// File: rtl/pcie_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping, as one-hot plus index.
// Latency: combinational.
// Backpressure: none; the caller decides when to accept the pick.
module pcie_rr_arbiter
    import pcie_egress_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               gnt_vld
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i is below 2*NUM_REQ, so one conditional subtract wraps it.
            cand = SUM_W'(ptr) + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!gnt_vld && req[cand[IDX_W-1:0]]) begin
                gnt_vld                = 1'b1;
                gnt[cand[IDX_W-1:0]]   = 1'b1;
                idx                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pcie_egress_scheduler.sv
// Round-robin share of the PCIe egress TLP engine; optional watchdog via PCIE_EGRESS_SCHED_TIMEOUT_EN.
// Latency: grant 1 cycle after request, o_eg_enable 2 cycles after request; FIFO routing combinational.
// Backpressure: requesters hold i_req until o_done; a new grant waits for i_eg_finished to drop.
module pcie_egress_scheduler
    import pcie_egress_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    pcie_egress_scheduler_if.master bus
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, done_q, arb_gnt;
    logic [IDX_W-1:0]     idx_q, ptr_q, arb_idx;
    logic                 arb_vld, finish_hit, timeout_hit, timeout_q, fifo_act_blk, grant_any;
    logic [CMD_W-1:0]     cmd_q;
    logic [FLAGS_W-1:0]   flags_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [TAG_W-1:0]     tag_q;
    logic [RID_W-1:0]     rid_q;

    pcie_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.i_req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        finish_hit = 1'b0;
        case (state_q)
            IDLE:    if (arb_vld) state_d = LATCH;
            LATCH:   state_d = ACTIVE;
            ACTIVE: begin
                if (bus.i_eg_finished || timeout_hit) begin
                    state_d    = RELEASE;
                    finish_hit = 1'b1;
                end
            end
            RELEASE: if (!bus.i_eg_finished) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            done_q  <= '0;
            cmd_q   <= '0;
            flags_q <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
            rid_q   <= '0;
        end else begin
            done_q <= finish_hit ? gnt_q : '0;
            if (state_q == IDLE && arb_vld) begin
                gnt_q <= arb_gnt;
                idx_q <= arb_idx;
            end
            // Header is sampled once; later requester changes are ignored.
            if (state_q == LATCH) begin
                cmd_q   <= `PES_SLICE(bus.i_req_command, idx_q, CMD_W);
                flags_q <= `PES_SLICE(bus.i_req_flags, idx_q, FLAGS_W);
                addr_q  <= `PES_SLICE(bus.i_req_address, idx_q, ADDR_W);
                tag_q   <= `PES_SLICE(bus.i_req_tag, idx_q, TAG_W);
                rid_q   <= bus.i_requester_id;
            end
            if (state_q == RELEASE && !bus.i_eg_finished) begin
                gnt_q <= '0;
                ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

`ifdef PCIE_EGRESS_SCHED_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                to_abort_q;

    assign timeout_hit  = (state_q == ACTIVE) && !bus.i_eg_finished && (to_cnt_q == TO_LAST);
    assign fifo_act_blk = to_abort_q || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q   <= '0;
            to_abort_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state_q == LATCH) begin
                to_cnt_q <= '0;
            end else if (state_q == ACTIVE) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            // Keep the aborted requester cut off from the engine until the grant is gone.
            if (timeout_hit) begin
                to_abort_q <= 1'b1;
            end else if (state_q == IDLE) begin
                to_abort_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign fifo_act_blk = 1'b0;
    assign timeout_q    = 1'b0;
`endif

    assign grant_any = |gnt_q;

    assign bus.o_gnt             = gnt_q;
    assign bus.o_done            = done_q;
    assign bus.o_timeout         = timeout_q;
    assign bus.o_eg_enable       = (state_q == ACTIVE);
    assign bus.o_eg_command      = cmd_q;
    assign bus.o_eg_flags        = flags_q;
    assign bus.o_eg_address      = addr_q;
    assign bus.o_eg_tag          = tag_q;
    assign bus.o_eg_requester_id = rid_q;

    assign bus.o_eg_fifo_rdy  = |(bus.i_req_fifo_rdy & gnt_q);
    assign bus.o_eg_fifo_size = grant_any ? `PES_SLICE(bus.i_req_fifo_size, idx_q, SIZE_W) : '0;
    assign bus.o_eg_fifo_data = grant_any ? `PES_SLICE(bus.i_req_fifo_data, idx_q, DATA_W) : '0;
    assign bus.o_req_fifo_act = gnt_q & {NUM_REQ{bus.i_eg_fifo_act && !fifo_act_blk}};
    assign bus.o_req_fifo_stb = gnt_q & {NUM_REQ{bus.i_eg_fifo_stb}};

endmodule

// File: doc/pcie_egress_scheduler.md
Name: pcie_egress_scheduler

Overview:
Shares the single PCIe egress TLP engine among NUM_REQ requesters (e.g. completion, memory-write and memory-read sources) using round-robin arbitration. It latches the winner's header fields, drives the engine's enable/finished handshake, and muxes the winner's outgoing-FIFO interface onto the engine. It sits between the requester blocks and the egress engine.

Parameters:
NUM_REQ, 3, number of requesters; 2..8
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles; used only with the optional feature

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester level request; held until o_done
o_gnt  out  NUM_REQ  one-hot grant; registered
o_done  out  NUM_REQ  one-cycle pulse when the granted transfer completes
o_timeout  out  1  one-cycle pulse on watchdog abort
i_req_command  in  8*NUM_REQ  packed TLP type per requester
i_req_flags  in  14*NUM_REQ  packed flags
i_req_address  in  32*NUM_REQ  packed address
i_req_tag  in  8*NUM_REQ  packed tag
i_requester_id  in  16  shared device ID
i_req_fifo_rdy  in  NUM_REQ  per-requester FIFO ready
o_req_fifo_act  out  NUM_REQ  routed FIFO activate
i_req_fifo_size  in  24*NUM_REQ  packed FIFO size in dwords
i_req_fifo_data  in  32*NUM_REQ  packed FIFO data
o_req_fifo_stb  out  NUM_REQ  routed FIFO strobe
o_eg_enable  out  1  egress engine enable
i_eg_finished  in  1  egress engine finished
o_eg_command  out  8  latched command
o_eg_flags  out  14  latched flags
o_eg_address  out  32  latched address
o_eg_requester_id  out  16  latched ID
o_eg_tag  out  8  latched tag
o_eg_fifo_rdy  out  1  muxed FIFO ready
i_eg_fifo_act  in  1  engine FIFO activate
o_eg_fifo_size  out  24  muxed FIFO size
o_eg_fifo_data  out  32  muxed FIFO data
i_eg_fifo_stb  in  1  engine FIFO strobe

Behaviour:
- Reset (async assert, sync release): state=IDLE; round-robin pointer=0; all outputs 0.
- FSM states: IDLE, LATCH, ACTIVE, RELEASE.
- IDLE: if any i_req is high, pick the first set bit searching from the pointer upward with wrap-around. Set o_gnt one-hot and go to LATCH. With no requests, stay in IDLE.
- LATCH: register the granted slice of command, flags, address and tag, plus i_requester_id, onto o_eg_*. Go to ACTIVE. Latency from i_req to o_eg_enable is 2 cycles.
- ACTIVE: o_eg_enable=1. When i_eg_finished=1: deassert o_eg_enable, pulse o_done for the granted requester, and go to RELEASE.
- RELEASE: wait for i_eg_finished=0 (engine back in IDLE). Then clear o_gnt, set pointer = granted index+1 mod NUM_REQ, and go to IDLE. Minimum 1 dead cycle between grants.
- FIFO routing is combinational, gated by o_gnt:
  - o_eg_fifo_rdy/size/data come from the granted slice.
  - i_eg_fifo_act/stb go only to the granted requester's o_req_fifo_act/stb.
  - Ungranted requesters see 0. With no grant, o_eg_fifo_* = 0.
- Header fields are latched once per grant. Requester changes after LATCH are ignored.
- i_req dropping while granted is ignored; the transfer runs to completion.
- i_eg_finished already high on entry to ACTIVE is treated as completion, same as a normal finish.
- Simultaneous requests: exactly one grant per transfer. A requester asserting in the same cycle another finishes waits for the next IDLE arbitration.
- Fairness: every continuously requesting requester is served within NUM_REQ grants.

Optional Feature:
Macro PCIE_EGRESS_SCHED_TIMEOUT_EN.
- With it defined: a 16-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle. When it reaches TIMEOUT_CYCLES-1 without finish: deassert o_eg_enable, pulse o_timeout and the granted o_done together, force o_req_fifo_act to 0, then go to RELEASE.
- Without it: no counter logic; o_timeout is tied 0 and ACTIVE waits indefinitely.

Decomposition:
- Shared package/defines (alongside the existing PCIe defines): FSM state encodings, field widths (8/14/32/24), and the packed-slice index helper macros.
- One sub-module: pcie_rr_arbiter. It is a combinational round-robin picker (req vector + pointer -> one-hot + index), reusable by the ingress side.

Test Plan:
- Single req[1], MWR, size 4 -> o_gnt=3'b010 one cycle after req; o_eg_enable 2 cycles after req; 4 FIFO strobes routed only to req 1; o_done[1] pulse; pointer=2.
- req=3'b111 held continuously, engine finishes after 10 cycles each -> grant order 0,1,2,0; no overlap; o_gnt never multi-hot.
- Req 0 changes command/address mid-ACTIVE -> o_eg_command/o_eg_address unchanged from the latched values.
- rst_n asserted in ACTIVE -> all outputs 0 immediately (asynchronously); after release the first grant goes to the lowest set request bit.
- i_eg_finished held high 3 cycles after completion -> no new grant until it falls; single o_done pulse.
- With macro defined and TIMEOUT_CYCLES=16, engine never finishes -> o_timeout and o_done pulse at ACTIVE cycle 16; enable drops; next requester is then granted.
